// File: rtl/router_register.sv
// Router datapath register stage: captures the packet header, steers bytes to the
// output FIFOs, tracks running parity and payload length, and flags errors.
module router_register (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err,
  output logic       len_err
);

  logic [7:0] header;
  logic [7:0] hold;
  logic [7:0] run_parity;
  logic [7:0] pkt_parity;
  logic [5:0] payload_cnt;
  logic       parity_done_q;

  logic header_ok;
  logic payload_beat;
  logic parity_beat;
  logic done_set;
  logic done_rise;

  always_comb begin
    header_ok    = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
    // A payload byte counts only while the controller is actually loading data.
    payload_beat = ld_state && pkt_valid && !full_state;
    parity_beat  = ld_state && !pkt_valid;
    done_set     = (ld_state && !fifo_full && !pkt_valid) ||
                   (laf_state && low_pkt_valid && !parity_done);
    done_rise    = parity_done && !parity_done_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header <= 8'h00;
    end else if (header_ok) begin
      header <= data_in;
    end
  end

  // Output steering; the priority order keeps behaviour defined even if decodes overlap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout <= 8'h00;
      hold <= 8'h00;
    end else if (lfd_state) begin
      dout <= header;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state && fifo_full) begin
      hold <= data_in;
    end else if (laf_state) begin
      dout <= hold;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (parity_beat) begin
      low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_done   <= 1'b0;
      parity_done_q <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      if (detect_add) begin
        parity_done <= 1'b0;
      end else if (done_set) begin
        parity_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_parity  <= 8'h00;
      pkt_parity  <= 8'h00;
      payload_cnt <= 6'd0;
    end else if (detect_add) begin
      run_parity  <= 8'h00;
      pkt_parity  <= 8'h00;
      payload_cnt <= 6'd0;
    end else begin
      if (lfd_state) begin
        run_parity <= run_parity ^ header;
      end else if (payload_beat) begin
        run_parity <= run_parity ^ data_in;
      end
      if (parity_beat) begin
        pkt_parity <= data_in;
      end
      // Saturate so an oversize packet still reports a length error instead of wrapping.
      if (payload_beat && (payload_cnt != 6'd63)) begin
        payload_cnt <= payload_cnt + 6'd1;
      end
    end
  end

  // Errors are judged once, the cycle after parity_done rises, when both parities are stable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (detect_add) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (done_rise) begin
      err     <= (run_parity != pkt_parity);
      len_err <= (payload_cnt != header[7:2]);
    end
  end

endmodule

// File: tb/tb_router_register.sv
// Directed testbench for router_register: each task plays the controller decode
// sequence for one scenario and compares the outputs against hand-derived values.
module tb_router_register;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic       len_err;

  int passed = 0;
  int total  = 0;

  router_register dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .len_err      (len_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    fifo_full   = 1'b0;
  endtask

  task automatic step_detect(input logic [7:0] h);
    set_idle();
    detect_add = 1'b1;
    pkt_valid  = 1'b1;
    data_in    = h;
    tick();
  endtask

  task automatic step_lfd();
    set_idle();
    lfd_state = 1'b1;
    pkt_valid = 1'b1;
    tick();
  endtask

  task automatic step_ld(input logic [7:0] d, input logic pv, input logic full);
    set_idle();
    ld_state  = 1'b1;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = full;
    tick();
  endtask

  task automatic step_full();
    set_idle();
    full_state = 1'b1;
    tick();
  endtask

  task automatic step_laf();
    set_idle();
    laf_state = 1'b1;
    tick();
  endtask

  task automatic step_idle();
    set_idle();
    tick();
  endtask

  task automatic step_rst_int();
    set_idle();
    rst_int_reg = 1'b1;
    pkt_valid   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    #3;
    total++; if (dout !== 8'h00) $display("FAIL rst_dout: got %h want 00", dout); else passed++;
    total++; if (parity_done !== 1'b0) $display("FAIL rst_parity_done: got %b want 0", parity_done); else passed++;
    total++; if (low_pkt_valid !== 1'b0) $display("FAIL rst_low_pkt_valid: got %b want 0", low_pkt_valid); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL rst_len_err: got %b want 0", len_err); else passed++;
    tick();
    resetn = 1'b1;
    step_idle();
    total++; if (dout !== 8'h00) $display("FAIL post_rst_dout: got %h want 00", dout); else passed++;
    total++; if (parity_done !== 1'b0) $display("FAIL post_rst_parity_done: got %b want 0", parity_done); else passed++;
  endtask

  task automatic test_good_packet();
    logic [7:0] p;
    p = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    step_detect(8'h0D);
    step_lfd();
    total++; if (dout !== 8'h0D) $display("FAIL good_hdr: got %h want 0D", dout); else passed++;
    step_ld(8'h11, 1'b1, 1'b0);
    total++; if (dout !== 8'h11) $display("FAIL good_b0: got %h want 11", dout); else passed++;
    step_ld(8'h22, 1'b1, 1'b0);
    total++; if (dout !== 8'h22) $display("FAIL good_b1: got %h want 22", dout); else passed++;
    step_ld(8'h33, 1'b1, 1'b0);
    total++; if (dout !== 8'h33) $display("FAIL good_b2: got %h want 33", dout); else passed++;
    step_ld(p, 1'b0, 1'b0);
    total++; if (dout !== p) $display("FAIL good_par: got %h want %h", dout, p); else passed++;
    total++; if (parity_done !== 1'b1) $display("FAIL good_parity_done: got %b want 1", parity_done); else passed++;
    total++; if (low_pkt_valid !== 1'b1) $display("FAIL good_low_pkt_valid: got %b want 1", low_pkt_valid); else passed++;
    step_idle();
    total++; if (err !== 1'b0) $display("FAIL good_err: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL good_len_err: got %b want 0", len_err); else passed++;
    step_rst_int();
    total++; if (low_pkt_valid !== 1'b0) $display("FAIL good_low_clear: got %b want 0", low_pkt_valid); else passed++;
    total++; if (parity_done !== 1'b1) $display("FAIL good_done_hold: got %b want 1", parity_done); else passed++;
  endtask

  task automatic test_bad_parity();
    step_detect(8'h0D);
    step_lfd();
    step_ld(8'h11, 1'b1, 1'b0);
    step_ld(8'h22, 1'b1, 1'b0);
    step_ld(8'h33, 1'b1, 1'b0);
    step_ld(8'hFF, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b1) $display("FAIL bad_parity_done: got %b want 1", parity_done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL bad_err_early: got %b want 0", err); else passed++;
    step_idle();
    total++; if (err !== 1'b1) $display("FAIL bad_err: got %b want 1", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL bad_len_err: got %b want 0", len_err); else passed++;
    step_idle();
    total++; if (err !== 1'b1) $display("FAIL bad_err_hold: got %b want 1", err); else passed++;
    step_rst_int();
    step_detect(8'h0D);
    total++; if (err !== 1'b0) $display("FAIL bad_err_clear: got %b want 0", err); else passed++;
    total++; if (parity_done !== 1'b0) $display("FAIL bad_done_clear: got %b want 0", parity_done); else passed++;
  endtask

  task automatic test_fifo_full();
    logic [7:0] p;
    p = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    step_detect(8'h0D);
    step_lfd();
    step_ld(8'h11, 1'b1, 1'b0);
    step_ld(8'h22, 1'b1, 1'b1);
    total++; if (dout !== 8'h11) $display("FAIL full_hold: got %h want 11", dout); else passed++;
    step_full();
    total++; if (dout !== 8'h11) $display("FAIL full_state_hold: got %h want 11", dout); else passed++;
    step_laf();
    total++; if (dout !== 8'h22) $display("FAIL full_laf: got %h want 22", dout); else passed++;
    step_ld(8'h33, 1'b1, 1'b0);
    total++; if (dout !== 8'h33) $display("FAIL full_b2: got %h want 33", dout); else passed++;
    step_ld(p, 1'b0, 1'b0);
    step_idle();
    total++; if (err !== 1'b0) $display("FAIL full_err: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL full_len_err: got %b want 0", len_err); else passed++;
    step_rst_int();
  endtask

  task automatic test_parity_when_full();
    logic [7:0] p;
    p = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    step_detect(8'h0D);
    step_lfd();
    step_ld(8'h11, 1'b1, 1'b0);
    step_ld(8'h22, 1'b1, 1'b0);
    step_ld(8'h33, 1'b1, 1'b0);
    step_ld(p, 1'b0, 1'b1);
    total++; if (dout !== 8'h33) $display("FAIL pfull_hold: got %h want 33", dout); else passed++;
    total++; if (parity_done !== 1'b0) $display("FAIL pfull_done_early: got %b want 0", parity_done); else passed++;
    total++; if (low_pkt_valid !== 1'b1) $display("FAIL pfull_low: got %b want 1", low_pkt_valid); else passed++;
    step_full();
    step_laf();
    total++; if (dout !== p) $display("FAIL pfull_laf: got %h want %h", dout, p); else passed++;
    total++; if (parity_done !== 1'b1) $display("FAIL pfull_done: got %b want 1", parity_done); else passed++;
    step_idle();
    total++; if (err !== 1'b0) $display("FAIL pfull_err: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL pfull_len_err: got %b want 0", len_err); else passed++;
    step_rst_int();
  endtask

  task automatic test_len_mismatch();
    logic [7:0] p;
    p = 8'h10 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3;
    step_detect(8'h10);
    step_lfd();
    step_ld(8'hA1, 1'b1, 1'b0);
    step_ld(8'hB2, 1'b1, 1'b0);
    step_ld(8'hC3, 1'b1, 1'b0);
    step_ld(p, 1'b0, 1'b0);
    step_idle();
    total++; if (err !== 1'b0) $display("FAIL len_err_parity: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b1) $display("FAIL len_mismatch: got %b want 1", len_err); else passed++;
    step_rst_int();
  endtask

  task automatic test_invalid_addr();
    step_detect(8'h03);
    total++; if (len_err !== 1'b0) $display("FAIL inv_len_clear: got %b want 0", len_err); else passed++;
    step_lfd();
    total++; if (dout !== 8'h10) $display("FAIL inv_header_kept: got %h want 10", dout); else passed++;
    step_idle();
  endtask

  task automatic test_low_priority();
    set_idle();
    ld_state    = 1'b1;
    rst_int_reg = 1'b1;
    pkt_valid   = 1'b0;
    data_in     = 8'h5A;
    tick();
    total++; if (low_pkt_valid !== 1'b0) $display("FAIL low_rst_wins: got %b want 0", low_pkt_valid); else passed++;
    step_idle();
  endtask

  task automatic test_saturation();
    logic [7:0] p;
    p = 8'hFC;
    step_detect(8'hFC);
    step_lfd();
    for (int i = 0; i < 70; i++) begin
      step_ld(8'(i + 1), 1'b1, 1'b0);
      p = p ^ 8'(i + 1);
    end
    step_ld(p, 1'b0, 1'b0);
    step_idle();
    total++; if (err !== 1'b0) $display("FAIL sat_err: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL sat_len_err: got %b want 0", len_err); else passed++;
    step_rst_int();
  endtask

  task automatic test_async_reset();
    logic [7:0] p;
    step_detect(8'h0D);
    step_lfd();
    step_ld(8'h11, 1'b1, 1'b0);
    step_ld(8'h22, 1'b1, 1'b0);
    step_ld(8'hFF, 1'b0, 1'b0);
    step_idle();
    step_detect(8'h0D);
    step_lfd();
    step_ld(8'h11, 1'b1, 1'b0);
    step_ld(8'h22, 1'b1, 1'b0);
    total++; if (low_pkt_valid !== 1'b1) $display("FAIL ar_pre_low: got %b want 1", low_pkt_valid); else passed++;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (dout !== 8'h00) $display("FAIL ar_dout: got %h want 00", dout); else passed++;
    total++; if (low_pkt_valid !== 1'b0) $display("FAIL ar_low: got %b want 0", low_pkt_valid); else passed++;
    total++; if (parity_done !== 1'b0) $display("FAIL ar_done: got %b want 0", parity_done); else passed++;
    #1;
    resetn = 1'b1;
    step_idle();
    total++; if (dout !== 8'h00) $display("FAIL ar_post_dout: got %h want 00", dout); else passed++;
    p = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    step_detect(8'h0D);
    step_lfd();
    total++; if (dout !== 8'h0D) $display("FAIL ar_hdr: got %h want 0D", dout); else passed++;
    step_ld(8'h11, 1'b1, 1'b0);
    step_ld(8'h22, 1'b1, 1'b0);
    step_ld(8'h33, 1'b1, 1'b0);
    step_ld(p, 1'b0, 1'b0);
    total++; if (dout !== p) $display("FAIL ar_par: got %h want %h", dout, p); else passed++;
    total++; if (parity_done !== 1'b1) $display("FAIL ar_parity_done: got %b want 1", parity_done); else passed++;
    step_idle();
    total++; if (err !== 1'b0) $display("FAIL ar_err: got %b want 0", err); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL ar_len_err: got %b want 0", len_err); else passed++;
    step_rst_int();
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full();
    test_parity_when_full();
    test_len_mismatch();
    test_invalid_addr();
    test_low_priority();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
